// File: rtl/delay_sched_pkg.sv
// Shared types and helpers for the round-robin delay-pipe scheduler.
package delay_sched_pkg;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_e;

  // Tag width helper; callers guarantee n >= 2.
  function automatic int sched_clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

endpackage

// File: rtl/delay_pipe_sched_rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant searching upward from ptr, plus granted index.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    idx
);

  logic [ID_W:0]   sum;
  logic [ID_W-1:0] j;

  always_comb begin
    gnt = '0;
    idx = '0;
    sum = '0;
    j   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      // Wrap explicitly so non-power-of-two requester counts rotate correctly.
      sum = {1'b0, ptr} + (ID_W+1)'(k);
      if (sum >= (ID_W+1)'(NUM_REQ)) sum = sum - (ID_W+1)'(NUM_REQ);
      j = sum[ID_W-1:0];
      if (req[j] && gnt == '0) begin
        gnt[j] = 1'b1;
        idx    = j;
      end
    end
  end

endmodule

// File: rtl/delay_pipe_sched.sv
// Round-robin scheduler feeding a shared, tagged DEPTH-stage delay pipe with flush/drain.
// Define DELAY_SCHED_CNT_EN to build the saturating per-requester grant counters.
module delay_pipe_sched
  import delay_sched_pkg::*;
#(
  parameter int  NUM_REQ = 4,
  parameter int  DATA_W  = 2,
  parameter int  DEPTH   = 3,
  localparam int ID_W    = sched_clog2(NUM_REQ)
) (
  input  logic                      sys_clk,
  input  logic                      sys_rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        gnt,
  input  logic                      flush,
  output logic                      busy,
  output logic                      flush_done,
  output logic                      out_valid,
  output logic [ID_W-1:0]           out_id,
  output logic [DATA_W-1:0]         led_out,
  output logic [NUM_REQ*8-1:0]      gnt_cnt
);

  typedef struct packed {
    logic              valid;
    logic [ID_W-1:0]   id;
    logic [DATA_W-1:0] data;
  } stage_t;

  state_e                         state;
  logic [ID_W-1:0]                ptr, gnt_idx;
  logic                           grant_ok, granted, pipe_empty;
  logic [NUM_REQ-1:0][DATA_W-1:0] req_vec;
  stage_t                         stage_in;
  stage_t                         pipe [DEPTH];

  assign req_vec  = req_data;
  // flush wins over req in the same cycle; nothing is accepted while draining.
  assign grant_ok = (state != FLUSH) && !flush;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
    .req (req & {NUM_REQ{grant_ok}}),
    .ptr (ptr),
    .gnt (gnt),
    .idx (gnt_idx)
  );

  assign granted  = |gnt;
  assign stage_in = {granted, gnt_idx, req_vec[gnt_idx]};

  always_comb begin
    pipe_empty = 1'b1;
    for (int k = 0; k < DEPTH; k++)
      if (pipe[k].valid) pipe_empty = 1'b0;
  end

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    stage_t src;
    if (k == 0) begin : g_src_in
      assign src = stage_in;
    end else begin : g_src_prev
      assign src = pipe[k-1];
    end

    if (k == DEPTH - 1) begin : g_last
      // Output stage keeps the last valid word visible across bubbles.
      always_ff @(posedge sys_clk)
        if (sys_rst) pipe[k] <= '0;
        else begin
          pipe[k].valid <= src.valid;
          if (src.valid) begin
            pipe[k].id   <= src.id;
            pipe[k].data <= src.data;
          end
        end
    end else begin : g_mid
      always_ff @(posedge sys_clk)
        if (sys_rst) pipe[k] <= '0;
        else         pipe[k] <= src;
    end
  end

  assign out_valid = pipe[DEPTH-1].valid;
  assign out_id    = pipe[DEPTH-1].id;
  assign led_out   = pipe[DEPTH-1].data;

  always_ff @(posedge sys_clk)
    if (sys_rst) begin
      state <= IDLE;
      ptr   <= '0;
    end else begin
      if (granted)
        ptr <= (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
      unique case (state)
        IDLE:    if (flush) state <= FLUSH;
                 else if (granted) state <= RUN;
        RUN:     if (flush) state <= FLUSH;
                 else if (!granted && pipe_empty) state <= IDLE;
        FLUSH:   if (pipe_empty) state <= IDLE;
        default: state <= IDLE;
      endcase
    end

  assign busy       = (state != IDLE);
  assign flush_done = (state == FLUSH) && pipe_empty;

`ifdef DELAY_SCHED_CNT_EN
  logic [NUM_REQ-1:0][7:0] cnt;

  always_ff @(posedge sys_clk)
    if (sys_rst) cnt <= '0;
    else
      for (int i = 0; i < NUM_REQ; i++)
        if (gnt[i] && cnt[i] != 8'hFF) cnt[i] <= cnt[i] + 8'd1;

  assign gnt_cnt = cnt;
`else
  assign gnt_cnt = '0;
`endif

endmodule

// File: tb/tb_delay_pipe_sched.sv
// Directed scoreboard bench for delay_pipe_sched (NUM_REQ=4, DATA_W=2, DEPTH=3).
module tb_delay_pipe_sched;

  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 2;
  localparam int DEPTH   = 3;
  localparam int ID_W    = 2;
`ifdef DELAY_SCHED_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic                      sys_clk = 1'b0;
  logic                      sys_rst = 1'b1;
  logic                      flush   = 1'b0;
  logic [NUM_REQ-1:0]        req     = '0;
  logic [NUM_REQ*DATA_W-1:0] req_data = '0;
  logic [NUM_REQ-1:0]        gnt;
  logic                      busy, flush_done, out_valid;
  logic [ID_W-1:0]           out_id;
  logic [DATA_W-1:0]         led_out;
  logic [NUM_REQ*8-1:0]      gnt_cnt;

  delay_pipe_sched #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .req        (req),
    .req_data   (req_data),
    .gnt        (gnt),
    .flush      (flush),
    .busy       (busy),
    .flush_done (flush_done),
    .out_valid  (out_valid),
    .out_id     (out_id),
    .led_out    (led_out),
    .gnt_cnt    (gnt_cnt)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    int         due;
    logic [1:0] id;
    logic [1:0] data;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;

  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: each expected word must appear exactly on its due cycle; all other cycles are bubbles.
  always @(negedge sys_clk) begin
    if (mon_en && !sys_rst) begin
      if (q.size() > 0 && q[0].due == cyc) begin
        check("out_valid", 32'(out_valid), 32'd1);
        check("out_id", 32'(out_id), 32'(q[0].id));
        check("led_out", 32'(led_out), 32'(q[0].data));
        void'(q.pop_front());
      end else begin
        check("bubble_valid", 32'(out_valid), 32'd0);
      end
    end
  end

  task automatic push(input logic [3:0] eg, input logic [7:0] d);
    exp_t e;
    int   id;
    id = 0;
    for (int i = 0; i < NUM_REQ; i++) if (eg[i]) id = i;
    e.due  = cyc + DEPTH;
    e.id   = 2'(id);
    e.data = d[id*2 +: 2];
    q.push_back(e);
  endtask

  task automatic step(input logic [3:0] r, input logic [7:0] d, input logic f, input logic [3:0] eg);
    @(posedge sys_clk);
    #1;
    req = r; req_data = d; flush = f;
    @(negedge sys_clk);
    check("gnt", 32'(gnt), 32'(eg));
    if (eg != 4'd0) push(eg, d);
  endtask

  task automatic idle(input int n);
    repeat (n) step(4'd0, 8'd0, 1'b0, 4'd0);
  endtask

  logic [3:0] rr_order [8] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
                               4'b0001, 4'b0010, 4'b0100, 4'b1000};

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    @(posedge sys_clk);
    @(negedge sys_clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_led_out", 32'(led_out), 32'd0);
    check("rst_out_id", 32'(out_id), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_flush_done", 32'(flush_done), 32'd0);
    check("rst_gnt_cnt", gnt_cnt, 32'd0);
    @(posedge sys_clk);
    #1;
    sys_rst = 1'b0;
    mon_en  = 1'b1;

    // 1: single request, latency and hold-on-bubble
    step(4'b0100, 8'h20, 1'b0, 4'b0100);
    idle(1);
    check("t1_busy_run", 32'(busy), 32'd1);
    idle(3);
    check("t1_hold_led", 32'(led_out), 32'd2);
    check("t1_hold_id", 32'(out_id), 32'd2);
    idle(1);
    check("t1_busy_idle", 32'(busy), 32'd0);

    // 2: bring pointer to 0, then all requesters for 8 cycles
    step(4'b1000, 8'h00, 1'b0, 4'b1000);
    for (int i = 0; i < 8; i++)
      step(4'b1111, (i % 2 == 0) ? 8'hE4 : 8'h1B, 1'b0, rr_order[i]);

    // 3: pointer to 2, then alternating 3/1 with wrap
    step(4'b0010, 8'h0C, 1'b0, 4'b0010);
    step(4'b1010, 8'hE4, 1'b0, 4'b1000);
    step(4'b1010, 8'h1B, 1'b0, 4'b0010);
    step(4'b1010, 8'h4E, 1'b0, 4'b1000);
    idle(5);
    check("t3_busy_idle", 32'(busy), 32'd0);

    // 4: three words in flight, flush beats req, drain in order
    step(4'b0001, 8'h03, 1'b0, 4'b0001);
    step(4'b0010, 8'h08, 1'b0, 4'b0010);
    step(4'b0100, 8'h20, 1'b0, 4'b0100);
    step(4'b0001, 8'hFF, 1'b1, 4'b0000);
    check("t4_fd0", 32'(flush_done), 32'd0);
    step(4'b0001, 8'hFF, 1'b1, 4'b0000);
    check("t4_fd1", 32'(flush_done), 32'd0);
    check("t4_busy1", 32'(busy), 32'd1);
    step(4'b0001, 8'hFF, 1'b0, 4'b0000);
    check("t4_fd2", 32'(flush_done), 32'd0);
    step(4'b0001, 8'hFF, 1'b0, 4'b0000);
    check("t4_fd3", 32'(flush_done), 32'd1);
    check("t4_busy3", 32'(busy), 32'd1);
    step(4'b0000, 8'h00, 1'b0, 4'b0000);
    check("t4_fd4", 32'(flush_done), 32'd0);
    check("t4_busy4", 32'(busy), 32'd0);

    // flush from IDLE with an empty pipe
    step(4'b0000, 8'h00, 1'b1, 4'b0000);
    check("idle_fl_fd0", 32'(flush_done), 32'd0);
    step(4'b0000, 8'h00, 1'b0, 4'b0000);
    check("idle_fl_fd1", 32'(flush_done), 32'd1);
    check("idle_fl_busy1", 32'(busy), 32'd1);
    step(4'b0000, 8'h00, 1'b0, 4'b0000);
    check("idle_fl_fd2", 32'(flush_done), 32'd0);
    check("idle_fl_busy2", 32'(busy), 32'd0);
    check("cnt_mid", gnt_cnt, CNT_EN ? 32'h05_04_05_03 : 32'd0);

    // 5: reset with two words in flight
    step(4'b1000, 8'hC0, 1'b0, 4'b1000);
    step(4'b0001, 8'h01, 1'b0, 4'b0001);
    @(posedge sys_clk);
    #1;
    sys_rst = 1'b1;
    req = '0;
    q.delete();
    @(posedge sys_clk);
    #1;
    sys_rst = 1'b0;
    @(negedge sys_clk);
    check("t5_out_valid", 32'(out_valid), 32'd0);
    check("t5_led_out", 32'(led_out), 32'd0);
    check("t5_out_id", 32'(out_id), 32'd0);
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_flush_done", 32'(flush_done), 32'd0);
    check("t5_gnt_cnt", gnt_cnt, 32'd0);
    idle(4);

    // 6: 300 grants to requester 0, counter saturates
    repeat (300) step(4'b0001, 8'h01, 1'b0, 4'b0001);
    step(4'b0000, 8'h00, 1'b0, 4'b0000);
    check("t6_gnt_cnt", gnt_cnt, CNT_EN ? 32'h0000_00FF : 32'd0);
    idle(4);
    check("sb_drained", 32'(q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
